lsm_sequencer: RTL and testbench

//  Parametrised load/store-multiple sequencer for the Memory stage. Walks a register list and

---
 rtl/lsm_sequencer_if.sv | 23 ++
 rtl/lsm_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_lsm_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsm_sequencer_if.sv
// Memory-side beat bus of the load/store-multiple sequencer.
// The sequencer is the master: it drives address, request strobes and store data.
interface lsm_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] busaddr;
    logic              rd_req;
    logic              wr_req;
    logic              rw_wait;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output busaddr, rd_req, wr_req, wr_data,
        input  rw_wait, rd_data
    );

    modport slave (
        input  busaddr, rd_req, wr_req, wr_data,
        output rw_wait, rd_data
    );
endinterface

// File: rtl/lsm_sequencer.sv
// Load/store-multiple sequencer: one bus beat per selected register, IA/IB/DA/DB modes.
// Optional LSM_CPSR_RESTORE_EN adds the SPSR->CPSR restore pulse on an LDM of the top register.
module lsm_sequencer #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     Nrst,
    input  logic                     start,
    input  logic                     load,
    input  logic                     up,
    input  logic                     pre,
    input  logic                     wb,
    input  logic                     sbit,
    input  logic [ADDR_W-1:0]        base,
    input  logic [$clog2(NREGS)-1:0] base_num,
    input  logic [NREGS-1:0]         reglist,
    lsm_sequencer_if.master          bus,
    output logic [$clog2(NREGS)-1:0] st_read,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     busy,
    output logic                     done,
    output logic                     write_reg,
    output logic [$clog2(NREGS)-1:0] write_num,
    output logic [DATA_W-1:0]        write_data,
    output logic                     restore_cpsr
);
    localparam int IDX_W  = $clog2(NREGS);
    localparam int STRIDE = DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] LOW_MASK = ~(ADDR_W'(STRIDE - 1));

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [NREGS-1:0]  rem_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] final_reg;
    logic              load_reg;
    logic              wb_reg;
    logic              base_in_list_reg;
    logic [IDX_W-1:0]  base_num_reg;

    logic [IDX_W:0]    count;
    logic [IDX_W-1:0]  cur_idx;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic              launch;
    logic              accept;
    logic              last_beat;
    logic              rd_req;
    logic              wr_req;

    always_comb begin
        count = '0;
        for (int i = 0; i < NREGS; i++) begin
            count = count + (IDX_W + 1)'(reglist[i]);
        end
    end

    // Lowest remaining register always goes to the lowest remaining address.
    always_comb begin
        cur_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (rem_reg[i]) cur_idx = IDX_W'(i);
        end
    end

    assign span      = ADDR_W'(count) * STRIDE_A;
    assign last_beat = (rem_reg & (rem_reg - NREGS'(1))) == '0;
    assign launch    = (state_reg == IDLE) && start;

    always_comb begin
        case ({up, pre})
            2'b10:   start_addr = base;
            2'b11:   start_addr = base + STRIDE_A;
            2'b00:   start_addr = base - span + STRIDE_A;
            default: start_addr = base - span;
        endcase
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (count == '0) ? FINISH : XFER;
            end
            XFER: begin
                rd_req = load_reg;
                wr_req = !load_reg;
                accept = !bus.rw_wait;
                if (accept && last_beat) state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.rd_req  = rd_req;
    assign bus.wr_req  = wr_req;
    assign bus.busaddr = addr_reg & LOW_MASK;
    assign bus.wr_data = st_data;
    assign st_read     = cur_idx;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            rem_reg          <= '0;
            addr_reg         <= '0;
            final_reg        <= '0;
            load_reg         <= 1'b0;
            wb_reg           <= 1'b0;
            base_in_list_reg <= 1'b0;
            base_num_reg     <= '0;
            write_reg        <= 1'b0;
            write_num        <= '0;
            write_data       <= '0;
        end else begin
            write_reg <= 1'b0;
            if (launch) begin
                rem_reg          <= reglist;
                addr_reg         <= start_addr;
                final_reg        <= up ? base + span : base - span;
                load_reg         <= load;
                // An empty list never writes the base back.
                wb_reg           <= wb && (count != '0);
                base_in_list_reg <= reglist[base_num];
                base_num_reg     <= base_num;
            end else if (accept) begin
                rem_reg  <= rem_reg & (rem_reg - NREGS'(1));
                addr_reg <= addr_reg + STRIDE_A;
                if (load_reg) begin
                    write_reg  <= 1'b1;
                    write_num  <= cur_idx;
                    write_data <= bus.rd_data;
                end
            end else if (state_reg == FINISH && wb_reg && (!load_reg || !base_in_list_reg)) begin
                // A loaded base register keeps the loaded value.
                write_reg  <= 1'b1;
                write_num  <= base_num_reg;
                write_data <= final_reg;
            end
        end
    end

`ifdef LSM_CPSR_RESTORE_EN
    logic restore_en_reg;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            restore_en_reg <= 1'b0;
            restore_cpsr   <= 1'b0;
        end else begin
            restore_cpsr <= 1'b0;
            if (launch) begin
                restore_en_reg <= load && sbit && reglist[NREGS-1];
            end else if (accept && load_reg && cur_idx == IDX_W'(NREGS - 1)) begin
                restore_cpsr <= restore_en_reg;
            end
        end
    end
`else
    logic unused_sbit;
    assign unused_sbit  = sbit;
    assign restore_cpsr = 1'b0;
`endif

endmodule

// File: tb/tb_lsm_sequencer.sv
// Self-checking bench for lsm_sequencer: directed scenarios plus randomized ops
// compared against a beat/write model derived from base, mode and register list.
module tb_lsm_sequencer;
    localparam int NREGS  = 16;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;
    localparam int S      = DATA_W / 8;
`ifdef LSM_CPSR_RESTORE_EN
    localparam int RESTORE_ON = 1;
`else
    localparam int RESTORE_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              Nrst = 1'b0;
    logic              start = 1'b0, load = 1'b0, up = 1'b0, pre = 1'b0, wb = 1'b0, sbit = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [IDX_W-1:0]  base_num = '0;
    logic [NREGS-1:0]  reglist = '0;
    logic [IDX_W-1:0]  st_read;
    logic [DATA_W-1:0] st_data;
    logic              busy, done, write_reg, restore_cpsr;
    logic [IDX_W-1:0]  write_num;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] regs [NREGS];

    lsm_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    lsm_sequencer #(.NREGS(NREGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .Nrst(Nrst), .start(start), .load(load), .up(up), .pre(pre),
        .wb(wb), .sbit(sbit), .base(base), .base_num(base_num), .reglist(reglist),
        .bus(bus), .st_read(st_read), .st_data(st_data), .busy(busy), .done(done),
        .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
        .restore_cpsr(restore_cpsr)
    );

    always #5 clk = ~clk;
    assign st_data = regs[st_read];

    int tests_run = 0;
    int tests_failed = 0;
    int writes_seen = 0;
    int restores_seen = 0;
    int last_wnum = 0;
    logic [DATA_W-1:0] last_wdata = '0;
    int last_done_cyc = 0;
    int last_waits = 0;
    bit mon_en = 1'b1;
    int exp_wnum[$];
    logic [DATA_W-1:0] exp_wdata[$];
    bit exp_wrst[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int m_num;
    logic [DATA_W-1:0] m_data;
    bit m_rst;

    // Regfile write-port monitor: every write must match the oldest expected write.
    always @(negedge clk) begin
        #1;
        if (mon_en && Nrst) begin
            if (restore_cpsr === 1'b1) restores_seen++;
            if (write_reg === 1'b1) begin
                writes_seen++;
                last_wnum  = int'(write_num);
                last_wdata = write_data;
                tests_run++;
                if (exp_wnum.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_write: got r%0d=%h, required no write", write_num, write_data);
                end else begin
                    m_num  = exp_wnum.pop_front();
                    m_data = exp_wdata.pop_front();
                    m_rst  = exp_wrst.pop_front();
                    if (int'(write_num) !== m_num || write_data !== m_data || restore_cpsr !== m_rst) begin
                        tests_failed++;
                        $display("FAIL write_port: got r%0d=%h rst=%b, required r%0d=%h rst=%b",
                                 write_num, write_data, restore_cpsr, m_num, m_data, m_rst);
                    end
                end
            end else if (restore_cpsr !== 1'b0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stray_restore: got restore_cpsr=%b without a write, required 0", restore_cpsr);
            end
        end
    end

    task automatic idle(input int c);
        start = 1'b0;
        repeat (c) @(negedge clk);
        #2;
    endtask

    // Launches one op at the current negedge and follows it to done.
    task automatic run_op(input bit ld, input bit u, input bit p, input bit w, input bit sb,
                          input logic [ADDR_W-1:0] b, input int bn, input logic [NREGS-1:0] rl,
                          input int wait_pct, input int fbeat, input int flen, input bit noise);
        int regq[$];
        logic [ADDR_W-1:0] addrq[$];
        logic [ADDR_W-1:0] fin, exp_a;
        int n, k, cyc, waits, held;
        bit rst_exp;
        for (int i = 0; i < NREGS; i++) if (rl[i]) regq.push_back(i);
        n = regq.size();
        // Walk the words away from base, then hand them out lowest address first.
        for (int m = 0; m < n; m++) begin
            if (u) addrq.push_back(b + ADDR_W'((m + int'(p)) * S));
            else   addrq.push_front(b - ADDR_W'((m + int'(p)) * S));
        end
        fin = u ? b + ADDR_W'(n * S) : b - ADDR_W'(n * S);

        load = ld; up = u; pre = p; wb = w; sbit = sb; base = b;
        base_num = IDX_W'(bn); reglist = rl; start = 1'b1;
        bus.rw_wait = 1'b0; bus.rd_data = $urandom;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL launch_idle: got busy=%b, required 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        obs_addr.delete();
        cyc = 0; k = 0; waits = 0; held = 0;
        forever begin
            cyc++;
            if (cyc > 200) begin
                tests_run++;
                tests_failed++;
                $display("FAIL done_timeout: got no done after 200 cycles, required done");
                break;
            end
            if (k == fbeat && held < flen) bus.rw_wait = 1'b1;
            else bus.rw_wait = ($urandom_range(99) < wait_pct);
            bus.rd_data = $urandom;
            if (noise) begin
                start = 1'($urandom_range(1)); base = $urandom;
                reglist = NREGS'($urandom); load = 1'($urandom_range(1));
            end
            #1;
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy: got %b at cycle %0d, required 1", busy, cyc);
            end
            if (bus.rd_req === 1'b1 || bus.wr_req === 1'b1) begin
                tests_run++;
                if (k >= n) begin
                    tests_failed++;
                    $display("FAIL extra_beat: got request at %h, required no beat (n=%0d)", bus.busaddr, n);
                end else begin
                    exp_a = addrq[k] & ~ADDR_W'(S - 1);
                    if (bus.busaddr !== exp_a || int'(st_read) !== regq[k] ||
                        bus.rd_req !== ld || bus.wr_req !== !ld) begin
                        tests_failed++;
                        $display("FAIL beat%0d: got addr=%h reg=%0d rd=%b wr=%b, required addr=%h reg=%0d rd=%b wr=%b",
                                 k, bus.busaddr, st_read, bus.rd_req, bus.wr_req, exp_a, regq[k], ld, !ld);
                    end
                    if (!ld) begin
                        tests_run++;
                        if (bus.wr_data !== regs[regq[k]]) begin
                            tests_failed++;
                            $display("FAIL store_data%0d: got %h, required %h", k, bus.wr_data, regs[regq[k]]);
                        end
                    end
                    if (bus.rw_wait) begin
                        waits++;
                        if (k == fbeat) held++;
                    end else begin
                        obs_addr.push_back(bus.busaddr);
                        if (ld) begin
                            rst_exp = (RESTORE_ON != 0) && sb && rl[NREGS-1] && regq[k] == NREGS - 1;
                            exp_wnum.push_back(regq[k]);
                            exp_wdata.push_back(bus.rd_data);
                            exp_wrst.push_back(rst_exp);
                        end
                        k++;
                    end
                end
            end
            if (done === 1'b1) begin
                tests_run++;
                if (k !== n || cyc !== n + waits + 1) begin
                    tests_failed++;
                    $display("FAIL done_timing: got beats=%0d cycle=%0d, required beats=%0d cycle=%0d",
                             k, cyc, n, n + waits + 1);
                end
                if (w && n > 0 && (!ld || !rl[bn])) begin
                    exp_wnum.push_back(bn);
                    exp_wdata.push_back(fin);
                    exp_wrst.push_back(1'b0);
                end
                break;
            end
            @(negedge clk);
        end
        last_done_cyc = cyc;
        last_waits = waits;
        @(negedge clk);
        start = 1'b0;
        bus.rw_wait = 1'b0;
    endtask

    task automatic check_drained(input string name);
        idle(2);
        tests_run++;
        if (exp_wnum.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d writes missing, required 0", name, exp_wnum.size());
            exp_wnum.delete(); exp_wdata.delete(); exp_wrst.delete();
        end
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if (busy !== 0 || done !== 0 || bus.rd_req !== 0 || bus.wr_req !== 0 || write_reg !== 0 ||
            restore_cpsr !== 0 || bus.busaddr !== 0 || write_num !== 0 || write_data !== 0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b rd=%b wr=%b wreg=%b rst=%b addr=%h wnum=%0d wdata=%h, required all 0",
                     busy, done, bus.rd_req, bus.wr_req, write_reg, restore_cpsr, bus.busaddr, write_num, write_data);
        end
        @(negedge clk);
        Nrst = 1'b1;
        idle(2);
        tests_run++;
        if (busy !== 0 || write_reg !== 0) begin
            tests_failed++;
            $display("FAIL reset_idle: got busy=%b write_reg=%b, required 0 0", busy, write_reg);
        end
    endtask

    task automatic test_ldm_ia;
        int w0;
        w0 = writes_seen;
        run_op(1, 1, 0, 0, 0, 32'h1000, 0, 16'h0013, 0, -1, 0, 0);
        tests_run++;
        if (obs_addr.size() != 3 || obs_addr[0] !== 32'h1000 || obs_addr[1] !== 32'h1004 ||
            obs_addr[2] !== 32'h1008 || last_done_cyc !== 4) begin
            tests_failed++;
            $display("FAIL ldm_ia: got %0d beats done_cycle=%0d, required 1000/1004/1008 done_cycle=4",
                     obs_addr.size(), last_done_cyc);
        end
        check_drained("ldm_ia");
        tests_run++;
        if (writes_seen - w0 !== 3) begin
            tests_failed++;
            $display("FAIL ldm_ia_writes: got %0d, required 3", writes_seen - w0);
        end
    endtask

    task automatic test_stm_db;
        run_op(0, 0, 1, 1, 0, 32'h2000, 13, 16'h8001, 0, -1, 0, 0);
        idle(1);
        tests_run++;
        if (obs_addr.size() != 2 || obs_addr[0] !== 32'h1FF8 || obs_addr[1] !== 32'h1FFC ||
            last_wnum !== 13 || last_wdata !== 32'h1FF8) begin
            tests_failed++;
            $display("FAIL stm_db: got %0d beats base write r%0d=%h, required 1FF8/1FFC and r13=1FF8",
                     obs_addr.size(), last_wnum, last_wdata);
        end
        check_drained("stm_db");
    endtask

    task automatic test_wait;
        int w0;
        w0 = writes_seen;
        run_op(1, 1, 1, 0, 0, 32'h0000_4000, 0, 16'h00F0, 0, 1, 3, 0);
        check_drained("wait");
        tests_run++;
        if (last_waits !== 3 || writes_seen - w0 !== 4) begin
            tests_failed++;
            $display("FAIL wait: got waits=%0d writes=%0d, required 3 4", last_waits, writes_seen - w0);
        end
    endtask

    task automatic test_base_in_list;
        int w0;
        w0 = writes_seen;
        run_op(1, 1, 0, 1, 0, 32'h0000_8000, 2, 16'h0006, 0, -1, 0, 0);
        check_drained("base_in_list");
        tests_run++;
        if (writes_seen - w0 !== 2) begin
            tests_failed++;
            $display("FAIL base_in_list: got %0d writes, required 2 (no base writeback)", writes_seen - w0);
        end
    endtask

    task automatic test_empty;
        int w0;
        w0 = writes_seen;
        run_op(1, 1, 0, 1, 0, 32'h0000_9000, 3, 16'h0000, 0, -1, 0, 0);
        check_drained("empty");
        tests_run++;
        if (last_done_cyc !== 1 || writes_seen - w0 !== 0) begin
            tests_failed++;
            $display("FAIL empty: got done_cycle=%0d writes=%0d, required 1 0", last_done_cyc, writes_seen - w0);
        end
    endtask

    task automatic test_reset_mid;
        int w0;
        mon_en = 1'b0;
        load = 1'b1; up = 1'b1; pre = 1'b0; wb = 1'b1; base = 32'h3000;
        base_num = 4'd14; reglist = 16'h00FF; start = 1'b1; bus.rw_wait = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        Nrst = 1'b0;
        #1;
        tests_run++;
        if (busy !== 0 || done !== 0 || bus.rd_req !== 0 || bus.wr_req !== 0 || write_reg !== 0 ||
            bus.busaddr !== 0 || write_num !== 0 || write_data !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid: got busy=%b rd=%b wr=%b wreg=%b addr=%h wnum=%0d wdata=%h, required all 0",
                     busy, bus.rd_req, bus.wr_req, write_reg, bus.busaddr, write_num, write_data);
        end
        exp_wnum.delete(); exp_wdata.delete(); exp_wrst.delete();
        @(negedge clk);
        @(negedge clk);
        Nrst = 1'b1;
        mon_en = 1'b1;
        w0 = writes_seen;
        idle(3);
        tests_run++;
        if (writes_seen - w0 !== 0 || busy !== 0) begin
            tests_failed++;
            $display("FAIL reset_abort: got writes=%0d busy=%b, required 0 0", writes_seen - w0, busy);
        end
        run_op(1, 0, 0, 1, 0, 32'h3000, 14, 16'h00FF, 0, -1, 0, 0);
        check_drained("reset_restart");
    endtask

    task automatic test_back_to_back;
        run_op(0, 1, 0, 1, 0, 32'h0000_A000, 5, 16'h0C30, 0, -1, 0, 0);
        run_op(1, 0, 1, 1, 0, 32'h0000_B000, 7, 16'h1111, 0, -1, 0, 0);
        run_op(0, 0, 1, 1, 0, 32'h0000_0004, 1, 16'h0007, 0, -1, 0, 0);
        check_drained("back_to_back");
    endtask

    task automatic test_restore;
        int r0;
        r0 = restores_seen;
        run_op(1, 1, 0, 0, 1, 32'h0000_5000, 0, 16'h8000, 0, -1, 0, 0);
        run_op(1, 1, 0, 0, 0, 32'h0000_5000, 0, 16'h8000, 0, -1, 0, 0);
        run_op(0, 1, 0, 0, 1, 32'h0000_5000, 0, 16'h8001, 0, -1, 0, 0);
        check_drained("restore");
        tests_run++;
        if (restores_seen - r0 !== RESTORE_ON) begin
            tests_failed++;
            $display("FAIL restore: got %0d pulses, required %0d", restores_seen - r0, RESTORE_ON);
        end
    endtask

    task automatic test_random;
        logic [ADDR_W-1:0] b;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(2))
                0:       b = $urandom & ~32'h3;
                1:       b = ADDR_W'($urandom_range(16)) * 4;
                default: b = 32'hFFFF_FFC0 + ADDR_W'($urandom_range(15)) * 4;
            endcase
            if ($urandom_range(3) == 0) b = b | ADDR_W'($urandom_range(3));
            run_op(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), b, $urandom_range(NREGS - 1),
                   NREGS'($urandom) & NREGS'($urandom), $urandom_range(40), -1, 0, 1'b1);
            if ($urandom_range(1) == 1) idle($urandom_range(2));
        end
        check_drained("random");
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        bus.rw_wait = 1'b0;
        bus.rd_data = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_ldm_ia;
        test_stm_db;
        test_wait;
        test_base_in_list;
        test_empty;
        test_reset_mid;
        test_back_to_back;
        test_restore;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
